// File: rtl/ifq_pkg.sv
// ifq_pkg: constants and types shared by the IF/ID instruction queue, the
// fetch unit and the NPC logic.
//   PC_RESET  - boot pc, also shown on the decode side while the queue is empty
//   INSTR_NOP - sll $0,$0,0, shown on the decode side while the queue is empty
//   ENTRY_W   - width of one {pc, instr} queue entry
//   ptr_w()   - pointer width for a DEPTH-entry queue (index bits plus a wrap bit)
package ifq_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
  localparam int          ENTRY_W   = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  // The extra MSB separates the full and empty cases when the index bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// ifq_storage: DEPTH x ENTRY_W register array for the IF/ID queue.
// It has one synchronous write port and one asynchronous read port. The
// contents are not reset; the queue pointers decide which entries are live.
//   clk   - clock
//   we    - write enable
//   waddr - write index
//   wdata - {pc, instr} entry to write
//   raddr - read index
//   rdata - entry at raddr (combinational)
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  ifq_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output ifq_entry_t    rdata
);

  ifq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: decoupling queue between fetch ({pc, instr}) and decode.
// It holds up to DEPTH entries and uses valid/ready handshakes on both sides.
// A flush, or a reset, drops every entry.
// Optional macro IFQ_BYPASS_EN: when the queue is empty, an incoming word is
// presented to decode combinationally. If decode takes it in the same cycle,
// the word is never written to the array.
//   clk, reset            - clock, synchronous active-high reset
//   flush                 - drop all entries (branch/jump redirect)
//   in_valid/in_ready     - fetch handshake; in_pc, in_instr carry the word
//   out_valid/out_ready   - decode handshake; out_pc, out_instr give the head
//   count                 - occupancy, 0..DEPTH
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = PC_RESET,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [31:0]           out_instr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  ifq_entry_t    rd_entry, wr_entry;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // in_ready depends on state only. A pop from a full queue frees a slot
  // starting in the next cycle.
  assign in_ready = !full;
  assign count    = wr_ptr - rd_ptr;
  assign wr_entry = '{pc: in_pc, instr: in_instr};

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = empty && !flush && in_valid;
  assign out_valid = !empty || bypass;
  // A bypassed word that decode accepts right away is consumed here and is not stored.
  assign push      = in_valid && in_ready && !(bypass && out_ready);
  assign pop       = !empty && out_ready;

  always_comb begin
    out_pc    = RESET_PC;
    out_instr = NOP_INSTR;
    if (!empty) begin
      out_pc    = rd_entry.pc;
      out_instr = rd_entry.instr;
    end else if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end
  end
`else
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_pc    = empty ? RESET_PC  : rd_entry.pc;
  assign out_instr = empty ? NOP_INSTR : rd_entry.instr;
`endif

  // Reset and flush have priority. Any push or pop in that same cycle is discarded.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  ifq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .clk   (clk),
    .we    (push && !flush && !reset),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;
  import ifq_pkg::*;

  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset, flush, in_valid, out_ready;
  logic                  in_ready, out_valid;
  logic [31:0]           in_pc, in_instr, out_pc, out_instr;
  logic [$clog2(DEPTH):0] count;

  int         checks = 0;
  int         errors = 0;
  ifq_entry_t sb[$];

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  function automatic logic [31:0] mk_instr(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = mk_instr(pc);
    out_ready = rdy;
    flush     = fl;
    #1;
  endtask

  // Scoreboard update for the coming rising edge, computed from the inputs being driven.
  task automatic model_commit;
    int n;
    bit thru;
    n    = sb.size();
    thru = 1'b0;
    if (reset || flush) sb.delete();
    else begin
`ifdef IFQ_BYPASS_EN
      thru = (n == 0) && in_valid && out_ready;
`endif
      if (out_ready && n > 0) void'(sb.pop_front());
      if (in_valid && n < DEPTH && !thru) sb.push_back('{pc: in_pc, instr: in_instr});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    repeat (2) @(negedge clk);
    model_commit();
    reset = 1'b0;
    drive(0, 32'h0, 0, 0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_pc !== 32'h0000_3000) begin errors++; $display("FAIL reset_out_pc got %h want 00003000", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h want 0", out_instr); end
    model_commit();
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 0, 0);
      checks++;
      if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready[%0d] got %0b want %0b", i, in_ready, (i < 4)); end
      model_commit();
    end
    drive(0, 32'h0, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b want 0", in_ready); end
    model_commit();
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 1, 0);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr)
        begin errors++; $display("FAIL drain[%0d] got v=%0b %h/%h want v=1 %h/%h", i, out_valid, out_pc, out_instr, sb[0].pc, sb[0].instr); end
      model_commit();
    end
    drive(0, 32'h0, 1, 0);
    checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL drain_empty got v=%0b cnt=%0d want v=0 cnt=0", out_valid, count); end
    model_commit();
  endtask

  task automatic test_streaming;
    drive(1, 32'h3000, 0, 0);
    model_commit();
    for (int i = 1; i <= 12; i++) begin
      drive(1, 32'h3000 + 32'(4 * i), 1, 0);
      checks++;
      if (count !== 3'd1 || out_pc !== sb[0].pc || out_instr !== sb[0].instr)
        begin errors++; $display("FAIL stream[%0d] got cnt=%0d %h/%h want cnt=1 %h/%h", i, count, out_pc, out_instr, sb[0].pc, sb[0].instr); end
      model_commit();
    end
    drive(0, 32'h0, 1, 0);
    checks++; if (out_pc !== 32'h3030) begin errors++; $display("FAIL stream_last got %h want 00003030", out_pc); end
    model_commit();
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h3020 + 32'(4 * i), 0, 0);
      model_commit();
    end
    drive(1, 32'h3040, 1, 1);
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3020) begin errors++; $display("FAIL flush_head got v=%0b %h want v=1 00003020", out_valid, out_pc); end
    model_commit();
    drive(0, 32'h0, 0, 0);
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL flush_after got cnt=%0d v=%0b rdy=%0b want 0/0/1", count, out_valid, in_ready); end
    model_commit();
    drive(1, 32'h3050, 0, 0);
    model_commit();
    drive(0, 32'h0, 1, 0);
    checks++; if (out_pc !== 32'h3050 || sb.size() != 1) begin errors++; $display("FAIL flush_stale got %h want 00003050", out_pc); end
    model_commit();
  endtask

  task automatic test_full_pop_push;
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h3060 + 32'(4 * i), 0, 0);
      model_commit();
    end
    drive(1, 32'h3070, 1, 0);
    checks++; if (in_ready !== 1'b0 || out_pc !== 32'h3060) begin errors++; $display("FAIL fullpop_cycle got rdy=%0b %h want rdy=0 00003060", in_ready, out_pc); end
    model_commit();
    drive(0, 32'h0, 0, 0);
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_count got cnt=%0d rdy=%0b want 3/1", count, in_ready); end
    model_commit();
    drive(1, 32'h3070, 0, 0);
    model_commit();
    drive(0, 32'h0, 0, 0);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_repush got cnt=%0d want 4", count); end
    model_commit();
    while (sb.size() > 0) begin
      drive(0, 32'h0, 1, 0);
      checks++;
      if (out_pc !== sb[0].pc || out_instr !== sb[0].instr)
        begin errors++; $display("FAIL fullpop_drain got %h/%h want %h/%h", out_pc, out_instr, sb[0].pc, sb[0].instr); end
      model_commit();
    end
  endtask

  task automatic test_latency;
    drive(1, 32'h3000, 1, 0);
`ifdef IFQ_BYPASS_EN
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3000 || out_instr !== mk_instr(32'h3000))
      begin errors++; $display("FAIL bypass_same got v=%0b %h want v=1 00003000", out_valid, out_pc); end
    model_commit();
    drive(0, 32'h0, 0, 0);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bypass_after got cnt=%0d v=%0b want 0/0", count, out_valid); end
    model_commit();
`else
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h3000) begin errors++; $display("FAIL latency_same got v=%0b %h want v=0 00003000", out_valid, out_pc); end
    model_commit();
    drive(0, 32'h0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || count !== 3'd1 || out_instr !== mk_instr(32'h3000))
      begin errors++; $display("FAIL latency_next got v=%0b cnt=%0d %h", out_valid, count, out_instr); end
    model_commit();
`endif
  endtask

  task automatic test_reset_mid;
    drive(1, 32'h3080, 0, 0); model_commit();
    drive(1, 32'h3084, 0, 0); model_commit();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    model_commit();
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h3000)
      begin errors++; $display("FAIL reset_mid got cnt=%0d v=%0b %h want 0/0/00003000", count, out_valid, out_pc); end
    model_commit();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_full_pop_push();
    test_latency();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1);
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue between the fetch unit (PC + instruction word) and the decode stage of the pipelined MIPS core.
- Buffers up to DEPTH fetched {pc, instr} pairs with valid/ready handshakes on both sides.
- Lets fetch run ahead while decode stalls.
- A flush input discards all buffered entries on branch/jump redirect.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- RESET_PC, 32'h00003000: pc value driven on out_pc when the queue is empty.
- NOP_INSTR, 32'h00000000: instruction driven on out_instr when the queue is empty (sll $0,$0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous discard of all entries (redirect from branch/jump resolution).
- in_valid  input  1  fetch presents a valid {in_pc, in_instr}.
- in_ready  output  1  queue accepts a push this cycle.
- in_pc  input  32  pc of the fetched word.
- in_instr  input  32  fetched instruction word.
- out_valid  output  1  head entry is valid for decode.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  32  pc of the head entry.
- out_instr  output  32  instruction of the head entry.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk.
- Storage:
  - DEPTH-entry array of 64-bit {pc, instr}.
  - wr_ptr and rd_ptr are each $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - Index is ptr[$clog2(DEPTH)-1:0].
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Push and pop:
  - in_ready = !full, purely combinational from state.
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - Push writes the array at wr_ptr and increments wr_ptr. Pop increments rd_ptr.
  - Push and pop in the same cycle are both performed; count is unchanged.
- Output:
  - out_valid = !empty.
  - When not empty, out_pc/out_instr = the array entry at rd_ptr.
  - When empty, out_pc = RESET_PC and out_instr = NOP_INSTR.
  - Outputs are stable while out_valid && !out_ready.
- Latency: a word pushed at edge N appears at the head no earlier than after edge N (1 cycle when the queue was empty).
- Full: in_ready = 0. A pop in a full cycle does not enable a same-cycle push; in_ready rises on the next cycle.
- Empty: out_valid = 0. An asserted out_ready is ignored and rd_ptr is not moved.
- Wrap-around: pointers wrap naturally; after 2*DEPTH push/pop pairs, order and contents must remain correct.
- Priority (highest first): reset, flush, normal push/pop.
  - flush = 1: wr_ptr and rd_ptr become 0 at the next edge. A same-cycle push and pop are discarded.
  - After flush, count = 0, out_valid = 0, and in_ready = 1 in the following cycle.
- Reset values: wr_ptr = rd_ptr = 0, so out_valid = 0, in_ready = 1, count = 0, out_pc = RESET_PC, out_instr = NOP_INSTR.
  - Array contents need not be reset.
  - Reset mid-operation drops all entries exactly like flush.
- No combinational path from in_* to out_* (unless the optional feature is compiled in). No path from out_ready to in_ready.

Optional Feature:
- Macro IFQ_BYPASS_EN.
- When defined, in a cycle with the queue empty, flush = 0 and in_valid = 1:
  - out_valid = 1, out_pc = in_pc, out_instr = in_instr, combinationally.
  - If out_ready = 1 as well, the word passes straight through: no write, pointers unchanged.
  - If out_ready = 0, the word is pushed normally.
- When undefined, there is no in-to-out combinational path and the minimum latency is 1 cycle.

Decomposition:
- Shared package ifq_pkg:
  - localparam PC_RESET = 32'h00003000
  - localparam INSTR_NOP = 32'h0
  - entry width 64
  - helper function for pointer width.
- These constants are shared with the fetch unit and the NPC logic.
- One natural sub-module: ifq_storage, a DEPTH x 64 register array with a single write port and an asynchronous read port.

Test Plan:
- Reset, then idle → out_valid = 0, in_ready = 1, count = 0, out_pc = 32'h00003000, out_instr = 0.
- Push pc 3000/3004/3008/300c with out_ready = 0 → count = 4, in_ready = 0. A fifth push of 3010 is refused. Draining yields 3000..300c in order.
- Push and pop simultaneously every cycle for 12 cycles (pcs 3000..302c) → count stays 1, outputs in order, pointers wrap correctly.
- Queue holding 3 entries; flush together with in_valid (pc 3040) → next cycle count = 0, out_valid = 0. 3040 is not present later.
- Full queue with pop and in_valid in the same cycle → pop occurs, no push, count = 3. The push succeeds the next cycle.
- IFQ_BYPASS_EN defined, queue empty, in_valid = 1, in_pc = 3000, out_ready = 1 → same-cycle out_valid = 1, out_pc = 3000. Next cycle count = 0.
